nxs_nonce_collector: RTL and testbench
======================================

# nxs_nonce_collector

Result end of the Nexus Skein hashing pipeline. It receives the 1024-bit state stream produced every clock by the two-block Skein pipeline. It recovers the nonce that produced each output from a latency-aligned counter and compares the selected 64-bit hash word against the share target. Winning nonces are queued in a small FIFO and presented to the host-side logic over a valid/ready handshake.

## Interface
- LATENCY, 245: clocks from a nonce entering the hasher core to its hash appearing on HashIn (123 + 122).
- COREIDX, 0: this core's nonce offset.
- HASHERS, 1: nonce stride between consecutive hashes of this core.
- FIFO_DEPTH, 4: winning-nonce queue entries (power of two, ≥2).
- CMP_WORD, 15: index of the 64-bit hash word compared against Target.

- clk  in  1  sole clock, rising edge.
- nHashRst  in  1  asynchronous, active-low reset.
- WorkLoad  in  1  single-cycle pulse: new work has entered the hasher core this edge.
- StartNonce  in  64  first nonce of the new work, sampled with WorkLoad.
- Target  in  64  share target, sampled with WorkLoad.
- HashIn  in  1024  pipeline output state, one hash per clock.
- NonceOut  out  64  head-of-queue winning nonce.
- NonceValid  out  1  queue non-empty.
- NonceReady  in  1  consumer accepts NonceOut.
- Flushing  out  1  pipeline still holds stale or pre-work hashes.
- Overflow  out  1  sticky: a winner was dropped because the queue was full.

## Operation
- States:
  - IDLE: after reset, no work loaded; HashIn ignored.
  - FLUSH: waiting for the first hash of the current work to reach HashIn.
  - RUN: every HashIn is evaluated.
- Transitions:
  - WorkLoad from any state → FLUSH. FlushCnt is loaded with LATENCY-1. TrackNonce is loaded with StartNonce+COREIDX and TargetReg with Target.
  - In FLUSH, FlushCnt decrements each edge. When FlushCnt==0 the state moves to RUN on the following edge.
  - With LATENCY=1, the FLUSH state lasts one cycle.
- Evaluation in RUN, per edge:
  - MatchReg <= (HashIn word CMP_WORD < TargetReg), unsigned.
  - MatchNonce <= TrackNonce.
  - TrackNonce <= TrackNonce + HASHERS, modulo 2^64 (wraps silently).
- Queue write: on the edge after MatchReg is set, MatchNonce is pushed if the queue is not full.
  - If the queue is full and no pop occurs that edge, the winner is dropped and Overflow is set.
  - If the queue is full and a pop occurs on the same edge, the push is accepted.
- Queue read: a pop occurs on any edge where NonceValid && NonceReady. NonceOut holds stable while NonceValid=1 and NonceReady=0.
- Push and pop on the same edge keep the occupancy unchanged. Ordering is strict FIFO.
- WorkLoad effects: it clears the queue, MatchReg, and Overflow on the same edge, so stale winners are discarded. A winner due to be pushed on that edge is discarded as well.
- WorkLoad during FLUSH restarts the flush from LATENCY-1.

## Timing
- Reset values (asynchronous, immediate on nHashRst=0):
  - state IDLE, FlushCnt 0, TrackNonce 0, TargetReg 0, MatchReg 0, queue empty.
  - NonceValid 0, NonceOut 0, Flushing 0, Overflow 0.
  - Release is synchronous to the next clk edge.
- Flushing = 1 exactly in FLUSH.
- Nonce alignment: with WorkLoad at edge T, HashIn sampled at edge T+LATENCY+k is attributed to StartNonce+COREIDX+k·HASHERS, for k ≥ 0. HashIn before edge T+LATENCY is never evaluated.
- Latency from a winning HashIn at edge E:
  - NonceValid=1 after edge E+2 when the queue was empty.
  - Otherwise the winner appears behind earlier entries.
- Throughput: one evaluation per clock and one pop per clock.
- Overflow stays high until WorkLoad or reset.

## Test plan
- Reset/idle (LATENCY=8, HASHERS=1, COREIDX=0):
  - Stimulus: hold nHashRst=0 mid-run, then release with winning HashIn every clock and no WorkLoad.
  - Response: all outputs 0 immediately; NonceValid stays 0.
- Alignment:
  - Stimulus: WorkLoad at edge T with StartNonce=0x100 and Target=0x8000000000000000; HashIn word15 = 0x1 only at edge T+11.
  - Response: Flushing=1 for 8 cycles; NonceOut=0x103 with NonceValid=1 after edge T+13; pop clears NonceValid.
- Stride/offset:
  - Stimulus: HASHERS=4, COREIDX=2, StartNonce=0x10; winner at k=3.
  - Response: NonceOut=0x1E.
- Backpressure/overflow:
  - Stimulus: NonceReady=0 with 6 consecutive winners at k=0..5 (FIFO_DEPTH=4).
  - Response: queue holds k=0..3 in order; Overflow=1.
  - Then assert NonceReady: 4 pops, in order.
- Full + simultaneous pop:
  - Stimulus: queue full, NonceReady=1, and a winner arrives.
  - Response: the winner is accepted, Overflow stays 0, and occupancy stays 4.
- WorkLoad mid-run and wrap:
  - Stimulus: queue holds 2 entries, then WorkLoad with StartNonce=0xFFFFFFFFFFFFFFFF.
  - Response: queue empties and Overflow clears on that edge; winners at k=0 and k=1 report 0xFFFFFFFFFFFFFFFF, then 0x0.

Source files
------------

// File: rtl/nxs_nonce_collector.sv
// rtl/nxs_nonce_collector.sv - Skein result collector: nonce recovery, target compare, winner queue
// Tracks which nonce each pipeline output belongs to and queues the ones that beat the share target.
module nxs_nonce_collector #(
    parameter int LATENCY    = 245,
    parameter int COREIDX    = 0,
    parameter int HASHERS    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CMP_WORD   = 15
) (
    input  logic          clk,
    input  logic          nHashRst,
    input  logic          WorkLoad,
    input  logic [63:0]   StartNonce,
    input  logic [63:0]   Target,
    input  logic [1023:0] HashIn,
    output logic [63:0]   NonceOut,
    output logic          NonceValid,
    input  logic          NonceReady,
    output logic          Flushing,
    output logic          Overflow
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = PW + 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_RUN
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_flush_cnt;
    logic [CW-1:0] w_flush_cnt_nxt;
    logic          w_eval;

    logic [63:0]   r_track_nonce;
    logic [63:0]   r_target;
    logic [63:0]   r_match_nonce;
    logic          r_match;
    logic [63:0]   w_hash_word;
    logic          w_unused_hash;

    logic [63:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [OW-1:0] r_ring_cnt;
    logic [63:0]   r_out;
    logic          r_out_valid;
    logic          r_overflow;
    logic [OW-1:0] w_occ;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_ring_rd;

    // Only one hash word takes part in the compare; the rest of the state is don't-care here.
    assign w_hash_word   = HashIn[CMP_WORD*64 +: 64];
    assign w_unused_hash = ^HashIn;

    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // The last FLUSH edge already carries the first hash of the new work, so it evaluates too.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_eval          = 1'b0;
        if (WorkLoad) begin
            w_state_nxt     = S_FLUSH;
            w_flush_cnt_nxt = CW'(LATENCY - 1);
        end else begin
            case (r_state)
                S_FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        w_state_nxt = S_RUN;
                        w_eval      = 1'b1;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt - CW'(1);
                    end
                end
                S_RUN:   w_eval = 1'b1;
                default: ;
            endcase
        end
    end

    assign Flushing = (r_state == S_FLUSH);

    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            r_track_nonce <= '0;
            r_target      <= '0;
            r_match_nonce <= '0;
            r_match       <= 1'b0;
        end else if (WorkLoad) begin
            r_track_nonce <= StartNonce + 64'(COREIDX);
            r_target      <= Target;
            r_match       <= 1'b0;
        end else begin
            r_match <= w_eval && (w_hash_word < r_target);
            if (w_eval) begin
                r_match_nonce <= r_track_nonce;
                r_track_nonce <= r_track_nonce + 64'(HASHERS);
            end
        end
    end

    // Queue = ring buffer feeding a registered head; occupancy counts both.
    assign w_pop     = r_out_valid && NonceReady;
    assign w_occ     = r_ring_cnt + OW'(r_out_valid);
    assign w_full    = (w_occ == OW'(FIFO_DEPTH));
    assign w_push    = r_match && (!w_full || w_pop);
    assign w_drop    = r_match && w_full && !w_pop;
    assign w_ring_rd = (r_ring_cnt != '0) && (!r_out_valid || w_pop);

    always_ff @(posedge clk) begin
        if (w_push && !WorkLoad) begin
            r_mem[r_wr_ptr] <= r_match_nonce;
        end
    end

    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ring_cnt  <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (WorkLoad) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ring_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_ring_rd) begin
                r_out    <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_ring_rd) begin
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            r_ring_cnt <= r_ring_cnt + OW'(w_push) - OW'(w_ring_rd);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign NonceOut   = r_out;
    assign NonceValid = r_out_valid;
    assign Overflow   = r_overflow;

endmodule

// File: tb/tb_nxs_nonce_collector.sv
// tb/tb_nxs_nonce_collector.sv - self-checking bench for nxs_nonce_collector
module tb_nxs_nonce_collector;
    localparam int L = 8;
    localparam int H = 1;
    localparam int C = 0;
    localparam int D = 4;
    localparam logic [63:0] LOSE = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] HALF = 64'h8000_0000_0000_0000;

    logic          clk = 1'b0;
    logic          nHashRst;
    logic          WorkLoad;
    logic [63:0]   StartNonce;
    logic [63:0]   Target;
    logic [1023:0] HashIn;
    logic          NonceReady;
    logic [63:0]   NonceOut, NonceOut2;
    logic          NonceValid, NonceValid2;
    logic          Flushing, Flushing2;
    logic          Overflow, Overflow2;

    always #5 clk = ~clk;

    nxs_nonce_collector #(.LATENCY(L), .COREIDX(C), .HASHERS(H), .FIFO_DEPTH(D), .CMP_WORD(15)) dut (
        .clk(clk), .nHashRst(nHashRst), .WorkLoad(WorkLoad), .StartNonce(StartNonce),
        .Target(Target), .HashIn(HashIn), .NonceOut(NonceOut), .NonceValid(NonceValid),
        .NonceReady(NonceReady), .Flushing(Flushing), .Overflow(Overflow));

    nxs_nonce_collector #(.LATENCY(L), .COREIDX(2), .HASHERS(4), .FIFO_DEPTH(D), .CMP_WORD(15)) dut2 (
        .clk(clk), .nHashRst(nHashRst), .WorkLoad(WorkLoad), .StartNonce(StartNonce),
        .Target(Target), .HashIn(HashIn), .NonceOut(NonceOut2), .NonceValid(NonceValid2),
        .NonceReady(NonceReady), .Flushing(Flushing2), .Overflow(Overflow2));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: winners are tagged with the edge they were queued on and
    // surface one edge later once they reach the head of the queue.
    typedef struct {
        logic [63:0] n;
        int          pe;
    } ent_t;

    ent_t        mq[$];
    int          cyc;
    bit          m_loaded;
    int          m_t0;
    logic [63:0] m_base, m_tgt, m_pend_n, m_head;
    bit          m_pend, m_ovf, m_valid, m_flush;

    always @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            mq.delete();
            cyc = 0; m_loaded = 0; m_pend = 0; m_ovf = 0; m_valid = 0; m_flush = 0;
            m_head = '0;
        end else begin
            cyc++;
            if (WorkLoad) begin
                mq.delete();
                m_pend = 0; m_ovf = 0; m_loaded = 1; m_t0 = cyc;
                m_base = StartNonce + 64'(C); m_tgt = Target;
            end else begin
                if (m_valid && NonceReady) void'(mq.pop_front());
                if (m_pend) begin
                    if (mq.size() < D) mq.push_back('{m_pend_n, cyc});
                    else m_ovf = 1;
                end
                m_pend = 0;
                if (m_loaded && cyc >= m_t0 + L) begin
                    m_pend   = (HashIn[1023:960] < m_tgt);
                    m_pend_n = m_base + 64'(cyc - m_t0 - L) * 64'(H);
                end
            end
            m_flush = m_loaded && (cyc < m_t0 + L);
            m_valid = (mq.size() > 0) && (mq[0].pe < cyc);
            m_head  = m_valid ? mq[0].n : 64'h0;
        end
    end

    always @(negedge clk) begin
        chk("model_valid", {63'h0, NonceValid}, {63'h0, m_valid});
        chk("model_flush", {63'h0, Flushing}, {63'h0, m_flush});
        chk("model_ovf", {63'h0, Overflow}, {63'h0, m_ovf});
        if (m_valid) chk("model_nonce", NonceOut, m_head);
    end

    // Word 15 carries the compared value; all other words are zero so a wrong word select wins.
    task automatic step(input logic [63:0] w);
        HashIn = '0;
        HashIn[1023:960] = w;
        @(negedge clk);
    endtask

    task automatic load_work(input logic [63:0] sn, input logic [63:0] tg);
        WorkLoad = 1'b1; StartNonce = sn; Target = tg;
        HashIn = '0; HashIn[1023:960] = LOSE;
        @(negedge clk);
        WorkLoad = 1'b0;
    endtask

    initial begin
        nHashRst = 1'b0; WorkLoad = 1'b0; NonceReady = 1'b0;
        StartNonce = '0; Target = '0; HashIn = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {63'h0, NonceValid}, 64'h0);
        chk("rst_nonce", NonceOut, 64'h0);
        chk("rst_flush", {63'h0, Flushing}, 64'h0);
        chk("rst_ovf", {63'h0, Overflow}, 64'h0);
        nHashRst = 1'b1;
        step(LOSE); step(LOSE);

        // Alignment: winner only at k=3
        load_work(64'h100, HALF);
        chk("align_flush_t0", {63'h0, Flushing}, 64'h1);
        for (int j = 1; j <= 13; j++) begin
            step(j == 11 ? 64'h1 : LOSE);
            if (j <= 7) chk("align_flush", {63'h0, Flushing}, 64'h1);
            if (j == 8) chk("align_flush_end", {63'h0, Flushing}, 64'h0);
            if (j == 12) chk("align_not_yet", {63'h0, NonceValid}, 64'h0);
        end
        chk("align_valid", {63'h0, NonceValid}, 64'h1);
        chk("align_nonce", NonceOut, 64'h103);
        NonceReady = 1'b1; step(LOSE); NonceReady = 1'b0;
        chk("align_pop", {63'h0, NonceValid}, 64'h0);

        // Stride/offset on the second instance
        load_work(64'h10, HALF);
        for (int j = 1; j <= 13; j++) step(j == 11 ? 64'h1 : LOSE);
        chk("stride_valid", {63'h0, NonceValid2}, 64'h1);
        chk("stride_nonce", NonceOut2, 64'h1E);
        chk("stride_nonce_ref", NonceOut, 64'h13);
        NonceReady = 1'b1; step(LOSE); NonceReady = 1'b0;

        // Backpressure and overflow: six winners into a four-deep queue
        load_work(64'h200, HALF);
        for (int j = 1; j <= 7; j++) step(LOSE);
        for (int j = 8; j <= 13; j++) step(64'h1);
        step(LOSE); step(LOSE);
        chk("bp_ovf", {63'h0, Overflow}, 64'h1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", {63'h0, NonceValid}, 64'h1);
            chk("bp_nonce", NonceOut, 64'h200 + 64'(i));
            NonceReady = 1'b1; step(LOSE);
        end
        NonceReady = 1'b0;
        chk("bp_empty", {63'h0, NonceValid}, 64'h0);

        // Full queue with a simultaneous pop accepts the winner
        load_work(64'h300, HALF);
        chk("full_ovf_clr", {63'h0, Overflow}, 64'h0);
        for (int j = 1; j <= 7; j++) step(LOSE);
        for (int j = 8; j <= 12; j++) step(64'h1);
        NonceReady = 1'b1; step(LOSE); NonceReady = 1'b0;
        chk("full_pop_ovf", {63'h0, Overflow}, 64'h0);
        chk("full_pop_head", NonceOut, 64'h301);
        step(64'h1); step(LOSE);
        chk("full_occ4_ovf", {63'h0, Overflow}, 64'h1);
        for (int i = 1; i <= 4; i++) begin
            chk("full_valid", {63'h0, NonceValid}, 64'h1);
            chk("full_nonce", NonceOut, 64'h300 + 64'(i));
            NonceReady = 1'b1; step(LOSE);
        end
        NonceReady = 1'b0;
        chk("full_empty", {63'h0, NonceValid}, 64'h0);

        // WorkLoad mid-run discards queue and pending winner; nonce wraps
        load_work(64'h400, HALF);
        chk("wl_ovf_clr", {63'h0, Overflow}, 64'h0);
        for (int j = 1; j <= 7; j++) step(LOSE);
        for (int j = 8; j <= 10; j++) step(64'h1);
        chk("wl_pre_valid", {63'h0, NonceValid}, 64'h1);
        chk("wl_pre_nonce", NonceOut, 64'h400);
        load_work(LOSE, HALF);
        chk("wl_clr_valid", {63'h0, NonceValid}, 64'h0);
        chk("wl_flush", {63'h0, Flushing}, 64'h1);
        for (int j = 1; j <= 7; j++) step(LOSE);
        step(64'h1); step(64'h1); step(LOSE);
        chk("wrap_valid0", {63'h0, NonceValid}, 64'h1);
        chk("wrap_nonce0", NonceOut, 64'hFFFF_FFFF_FFFF_FFFF);
        NonceReady = 1'b1; step(LOSE);
        chk("wrap_valid1", {63'h0, NonceValid}, 64'h1);
        chk("wrap_nonce1", NonceOut, 64'h0);
        step(LOSE); NonceReady = 1'b0;
        chk("wrap_empty", {63'h0, NonceValid}, 64'h0);

        // Asynchronous reset mid-run, then winning hashes with no work loaded
        load_work(64'h500, HALF);
        for (int j = 1; j <= 7; j++) step(LOSE);
        for (int j = 8; j <= 11; j++) step(64'h1);
        step(LOSE);
        #2 nHashRst = 1'b0;
        #1;
        chk("arst_valid", {63'h0, NonceValid}, 64'h0);
        chk("arst_nonce", NonceOut, 64'h0);
        chk("arst_flush", {63'h0, Flushing}, 64'h0);
        chk("arst_ovf", {63'h0, Overflow}, 64'h0);
        HashIn = '0;
        repeat (2) @(negedge clk);
        nHashRst = 1'b1;
        for (int j = 0; j < 20; j++) begin
            step(64'h0);
            chk("idle_valid", {63'h0, NonceValid}, 64'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
